// File: rtl/tb_result_checker.sv
// Scoreboard stage: queues expected samples, compares DUT output samples in order,
// counts errors and latches a pass/fail verdict after end-of-stimulus.
module tb_result_checker #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exp_valid,
  input  logic [DATA_WIDTH-1:0] exp_data,
  output logic                  exp_ready,
  input  logic                  act_valid,
  input  logic [DATA_WIDTH-1:0] act_data,
  input  logic                  done,
  output logic                  mismatch,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  cmp_count,
  output logic                  finished,
  output logic                  test_passed
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;

  logic running;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic act_seen;
  logic err;

  assign running   = (state == ST_RUN);
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign exp_ready = running && !full;
  assign push      = exp_valid && exp_ready;
  assign act_seen  = running && act_valid;
  // An empty FIFO is an underrun even if a push lands this cycle: no bypass path.
  assign pop       = act_seen && !empty;
  assign err       = act_seen && (empty || (mem[rd_ptr] != act_data));

  // NOTE: storage array has no reset; validity is tracked solely by count/pointers,
  // so clearing those on reset discards the contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= exp_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      mismatch    <= 1'b0;
      err_count   <= '0;
      cmp_count   <= '0;
      finished    <= 1'b0;
      test_passed <= 1'b0;
    end else begin
      mismatch <= err;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      if (act_seen && (cmp_count != '1)) cmp_count <= cmp_count + CNT_WIDTH'(1);
      if (err && (err_count != '1))      err_count <= err_count + CNT_WIDTH'(1);

      case (state)
        ST_RUN: begin
          if (done) state <= ST_CHECK;
        end
        ST_CHECK: begin
          // Counters already include the last RUN-cycle error here.
          state       <= ST_DONE;
          finished    <= 1'b1;
          test_passed <= (err_count == '0) && empty && (cmp_count != '0);
        end
        default: state <= ST_DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_tb_result_checker.sv
// Bench for tb_result_checker: directed test-plan scenarios plus randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_tb_result_checker;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int CW    = 6;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          exp_valid;
  logic [DW-1:0] exp_data;
  logic          exp_ready;
  logic          act_valid;
  logic [DW-1:0] act_data;
  logic          done;
  logic          mismatch;
  logic [CW-1:0] err_count;
  logic [CW-1:0] cmp_count;
  logic          finished;
  logic          test_passed;

  tb_result_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
    .act_valid(act_valid), .act_data(act_data), .done(done),
    .mismatch(mismatch), .err_count(err_count), .cmp_count(cmp_count),
    .finished(finished), .test_passed(test_passed)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of expectations, counters, and a phase 0=run 1=check 2=done.
  logic [DW-1:0] q[$];
  int            m_phase;
  int            m_err;
  int            m_cmp;
  bit            m_mis;
  bit            m_fin;
  bit            m_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_phase = 0; m_err = 0; m_cmp = 0;
    m_mis = 0; m_fin = 0; m_pass = 0;
  endtask

  task automatic check_outs();
    check("mismatch",    32'(mismatch),    32'(m_mis));
    check("err_count",   32'(err_count),   32'(m_err));
    check("cmp_count",   32'(cmp_count),   32'(m_cmp));
    check("finished",    32'(finished),    32'(m_fin));
    check("test_passed", 32'(test_passed), 32'(m_pass));
  endtask

  task automatic step(input bit rs, input bit ev, input logic [DW-1:0] ed,
                      input bit av, input logic [DW-1:0] ad, input bit dn);
    bit m_ready;
    bit e;
    logic [DW-1:0] h;
    @(negedge clk);
    rst_n = rs; exp_valid = ev; exp_data = ed;
    act_valid = av; act_data = ad; done = dn;
    #1;
    m_ready = (m_phase == 0) && (q.size() < DEPTH);
    check("exp_ready", 32'(exp_ready), 32'(m_ready));
    if (!rs) begin
      model_clear();
    end else if (m_phase == 0) begin
      e = 0;
      if (av) begin
        if (m_cmp < CMAX) m_cmp++;
        if (q.size() > 0) begin
          h = q.pop_front();
          e = (h != ad);
        end else begin
          e = 1;
        end
        if (e && m_err < CMAX) m_err++;
      end
      if (ev && m_ready) q.push_back(ed);
      m_mis = e;
      if (dn) m_phase = 1;
    end else if (m_phase == 1) begin
      m_phase = 2;
      m_fin   = 1;
      m_pass  = (m_err == 0) && (q.size() == 0) && (m_cmp != 0);
      m_mis   = 0;
    end else begin
      m_mis = 0;
    end
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic idle();
    step(1, 0, '0, 0, '0, 0);
  endtask

  task automatic push(input logic [DW-1:0] d);
    step(1, 1, d, 0, '0, 0);
  endtask

  task automatic act(input logic [DW-1:0] d);
    step(1, 0, '0, 1, d, 0);
  endtask

  task automatic finish_test(input bit want_pass);
    step(1, 0, '0, 0, '0, 1);
    idle();
    idle();
    check("verdict_fin",  32'(finished),    32'd1);
    check("verdict_pass", 32'(test_passed), 32'(want_pass));
  endtask

  task automatic do_reset();
    step(0, 0, '0, 0, '0, 0);
  endtask

  initial begin
    logic [DW-1:0] hd;
    rst_n = 0; exp_valid = 0; exp_data = '0; act_valid = 0; act_data = '0; done = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_outs();
    check("rst_ready", 32'(exp_ready), 32'd1);

    // Five matching samples.
    for (int i = 1; i <= 5; i++) push(DW'(i));
    for (int i = 1; i <= 5; i++) act(DW'(i));
    check("five_err", 32'(err_count), 32'd0);
    check("five_cmp", 32'(cmp_count), 32'd5);
    finish_test(1);

    // Single mismatch.
    do_reset();
    push(16'h00AA);
    act(16'h00AB);
    check("mis_pulse", 32'(mismatch), 32'd1);
    idle();
    finish_test(0);

    // Underrun: push and act together on an empty FIFO.
    do_reset();
    step(1, 1, 16'h0033, 1, 16'h0033, 0);
    check("under_err", 32'(err_count), 32'd1);
    check("under_occ", 32'(q.size()), 32'd1);
    finish_test(0);

    // Fill, refused push at full, then traffic across pointer wrap.
    do_reset();
    for (int i = 0; i < 16; i++) push(DW'(16'h0100 + i));
    check("full_ready", 32'(exp_ready), 32'd0);
    hd = q[0];
    step(1, 1, 16'hDEAD, 1, hd, 0);
    check("full_occ", 32'(q.size()), 32'd15);
    for (int i = 0; i < 17; i++) begin
      hd = q[0];
      step(1, 1, DW'(16'h0200 + i), 1, hd, 0);
    end
    while (q.size() > 0) begin
      hd = q[0];
      act(hd);
    end
    check("wrap_err", 32'(err_count), 32'd0);
    finish_test(1);

    // Last act mismatches in the same cycle as done.
    do_reset();
    for (int i = 0; i < 3; i++) push(DW'(16'h0010 + i));
    act(16'h0010);
    act(16'h0011);
    step(1, 0, '0, 1, 16'h0099, 1);
    idle();
    idle();
    check("late_err",  32'(err_count),   32'd1);
    check("late_pass", 32'(test_passed), 32'd0);

    // Reset mid-run discards queued entries.
    do_reset();
    for (int i = 0; i < 4; i++) push(DW'(16'h0040 + i));
    do_reset();
    check("mid_rst_ready", 32'(exp_ready), 32'd1);
    finish_test(0);

    // Saturation through repeated underruns.
    do_reset();
    for (int i = 0; i < 70; i++) act(DW'(i));
    check("sat_err", 32'(err_count), 32'(CMAX));
    check("sat_cmp", 32'(cmp_count), 32'(CMAX));
    finish_test(0);

    // Randomized rounds; stray traffic continues through CHECK/DONE.
    for (int r = 0; r < 6; r++) begin
      int len;
      do_reset();
      len = $urandom_range(20, 80);
      for (int c = 0; c < len + 4; c++) begin
        bit ev, av, dn;
        logic [DW-1:0] ed, ad;
        ev = ($urandom % 2) == 0;
        ed = DW'($urandom);
        av = ($urandom % 3) == 0;
        ad = (q.size() > 0 && ($urandom % 6) != 0) ? q[0] : DW'($urandom);
        dn = (c == len);
        step(1, ev, ed, av, ad, dn);
      end
      check("rnd_fin", 32'(finished), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
